seg_scan_ctrl: RTL

//   Time-multiplexed scan controller for a NUM_DIGITS-digit seven-segment display.
//   - Holds a packed BCD display value.
//   - Steps through the digits one at a time. For each digit it presents that digit's

---
 rtl/seg_scan_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed seven-segment scan controller
//
// Scans NUM_DIGITS digits one at a time with a blanking gap before each digit.
// New display values arrive over a valid/ready handshake and are committed only
// at the frame boundary (last digit SHOW -> digit 0 BLANK), so a frame never tears.
//
// Ports:
//   clk          clock, all state updates on rising edge
//   rst          synchronous active-high reset
//   load_valid   load_bcd holds a new value
//   load_ready   controller accepts a value this cycle
//   load_bcd     packed BCD nibbles, [3:0] = digit 0
//   lz_blank_en  1 = blank leading zeros (sampled every SHOW cycle)
//   bcd_out      nibble to the shared decoder, 4'hF = blank
//   digit_en     one-hot digit enable, all-zero during BLANK
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_bcd,
    input  logic                    lz_blank_en,
    output logic [3:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_en
);

    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] LAST_DIGIT = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           digit_idx;
    logic [4*NUM_DIGITS-1:0] display;
    logic [4*NUM_DIGITS-1:0] pend_data;
    logic                    pending;

    logic                    xfer;
    logic                    frame_end;
    logic [NUM_DIGITS-1:0]   zero_above;
    logic                    run_zero;
    logic [3:0]              cur_nib;
    logic [NUM_DIGITS-1:0]   onehot;

    assign xfer      = load_valid && load_ready;
    assign frame_end = (state == ST_SHOW) && (cnt == SHOW_LAST) && (digit_idx == LAST_DIGIT);

    // zero_above[i] = 1 when every nibble from the top digit down to i is zero.
    // Bit 0 stays clear so digit 0 is never blanked.
    always_comb begin
        zero_above = '0;
        run_zero   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            run_zero      = run_zero & (display[4*i +: 4] == 4'h0);
            zero_above[i] = run_zero;
        end
    end

    always_comb begin
        cur_nib = display[{digit_idx, 2'b00} +: 4];
        if (lz_blank_en && zero_above[digit_idx]) begin
            cur_nib = 4'hF;
        end
    end

    always_comb begin
        onehot            = '0;
        onehot[digit_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            digit_idx  <= '0;
            display    <= '1;
            pend_data  <= '1;
            pending    <= 1'b0;
            load_ready <= 1'b0;
            bcd_out    <= 4'hF;
            digit_en   <= '0;
        end else begin
            // Handshake: ready re-opens one edge after pending clears, and drops
            // on the edge that captures a transfer.
            if (xfer) begin
                pend_data <= load_bcd;
            end
            pending    <= xfer | (pending & ~frame_end);
            load_ready <= ~pending & ~xfer;

            case (state)
                ST_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state    <= ST_SHOW;
                        cnt      <= '0;
                        digit_en <= onehot;
                        bcd_out  <= cur_nib;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        digit_en <= '0;
                        bcd_out  <= 4'hF;
                    end
                end
                ST_SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state    <= ST_BLANK;
                        cnt      <= '0;
                        digit_en <= '0;
                        bcd_out  <= 4'hF;
                        if (digit_idx == LAST_DIGIT) begin
                            digit_idx <= '0;
                            // Commit uses the pending flag from before this edge.
                            if (pending) begin
                                display <= pend_data;
                            end
                        end else begin
                            digit_idx <= digit_idx + 1'b1;
                        end
                    end else begin
                        cnt      <= cnt + 1'b1;
                        digit_en <= onehot;
                        bcd_out  <= cur_nib;
                    end
                end
                default: begin
                    state    <= ST_BLANK;
                    cnt      <= '0;
                    digit_en <= '0;
                    bcd_out  <= 4'hF;
                end
            endcase
        end
    end

endmodule
